// File: rtl/sr_cmd_conditioner_pkg.sv
// sr_cmd_conditioner shared types.
// FSM states, pending-slot encoding, helpers.
package sr_cmd_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_S    = 2'd1,
    PEND_R    = 2'd2
  } pend_e;

  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_cmd_conditioner_debounce.sv
// Button conditioner: 2-flop sync, debounce,
// and a rise strobe on the accepted level.
module sr_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CW =
    $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count disagreeing cycles; flip level on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == TERM) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = level_d & ~level_q;

  // Synchroniser, debounced level and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Command stage for the SR latch: clean,
// exclusive, gap-separated S/R pulses.
module sr_cmd_conditioner
  import sr_cmd_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_WIDTH     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict,
  output logic overrun
);

  localparam int unsigned PW_W =
    cnt_width(PULSE_WIDTH);
  localparam logic [PW_W-1:0] PW_LAST =
    PW_W'(PULSE_WIDTH - 1);

  logic rise_s;
  logic rise_r;
  logic req_s_q;
  logic req_r_q;
  logic req_s;
  logic req_r;
  logic go_s;
  logic go_r;
  logic conflict_q;

  state_e          state_q;
  pend_e           pend_q;
  pend_e           pend_busy;
  logic            ovr_busy;
  logic [PW_W-1:0] cnt_q;
  logic            s_q;
  logic            r_q;
  logic            busy_q;
  logic            ovr_q;

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_set (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (set_btn),
    .rise_o(rise_s)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (rst_btn),
    .rise_o(rise_r)
  );

  // Register press strobes; flag same-cycle presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_s_q    <= 1'b0;
      req_r_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      req_s_q    <= rise_s;
      req_r_q    <= rise_r;
      conflict_q <= rise_s & rise_r;
    end
  end

  // Simultaneous presses cancel each other.
  assign req_s = req_s_q & ~req_r_q;
  assign req_r = req_r_q & ~req_s_q;

  // A fresh press beats an opposite stale slot.
  assign go_s = req_s |
    ((pend_q == PEND_S) & ~req_r);
  assign go_r = req_r |
    ((pend_q == PEND_R) & ~req_s);

  // Slot update for a request arriving while busy.
  always_comb begin
    pend_busy = pend_q;
    ovr_busy  = 1'b0;
    unique case (1'b1)
      req_s: begin
        ovr_busy  = (pend_q == PEND_R);
        pend_busy = PEND_S;
      end
      req_r: begin
        ovr_busy  = (pend_q == PEND_S);
        pend_busy = PEND_R;
      end
      default: ;
    endcase
  end

  // Pulse FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= PEND_NONE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (go_s) begin
            state_q <= ST_PULSE_S;
            cnt_q   <= '0;
            s_q     <= 1'b1;
            busy_q  <= 1'b1;
            pend_q  <= PEND_NONE;
            ovr_q   <= req_s &
              (pend_q == PEND_R);
          end else if (go_r) begin
            state_q <= ST_PULSE_R;
            cnt_q   <= '0;
            r_q     <= 1'b1;
            busy_q  <= 1'b1;
            pend_q  <= PEND_NONE;
            ovr_q   <= req_r &
              (pend_q == PEND_S);
          end
        end
        ST_PULSE_S, ST_PULSE_R: begin
          pend_q <= pend_busy;
          ovr_q  <= ovr_busy;
          if (cnt_q == PW_LAST) begin
            state_q <= ST_GAP;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          pend_q  <= pend_busy;
          ovr_q   <= ovr_busy;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner: event
// scoreboard plus per-cycle invariants.
module tb_sr_cmd_conditioner;

  localparam int PW0 = 2;
  localparam int PW1 = 16;
  localparam int LAT = 7;

  typedef struct {
    byte kind;
    int  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic set0, rst0, set1, rst1;
  logic s0, r0, busy0, cf0, ov0;
  logic s1, r1, busy1, cf1, ov1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic ps0 = 1'b0, pr0 = 1'b0;
  logic ps1 = 1'b0, pr1 = 1'b0;
  int   run0 = 0, run1 = 0;

  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_WIDTH    (PW0)
  ) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_btn (set0),
    .rst_btn (rst0),
    .S       (s0),
    .R       (r0),
    .busy    (busy0),
    .conflict(cf0),
    .overrun (ov0)
  );

  // Long pulses leave room to stack requests.
  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_WIDTH    (PW1)
  ) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_btn (set1),
    .rst_btn (rst1),
    .S       (s1),
    .R       (r1),
    .busy    (busy1),
    .conflict(cf1),
    .overrun (ov1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic push(
    input int  id,
    input byte k,
    input int  c
  );
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic ev(
    input int  id,
    input byte k
  );
    exp_t e;
    bit   empty;
    empty = (id == 0) ? (q0.size() == 0)
                      : (q1.size() == 0);
    if (empty) begin
      chk($sformatf("u%0d_unexpected_%c", id, k),
          int'(k), 0);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    chk($sformatf("u%0d_kind", id),
        int'(k), int'(e.kind));
    chk($sformatf("u%0d_cycle_%c", id, e.kind),
        cyc, e.cyc);
  endtask

  // Monitor for unit 0.
  always @(negedge clk) begin
    chk("u0_excl", int'(s0 & r0), 0);
    if (!rst_n) begin
      ps0  = 1'b0;
      pr0  = 1'b0;
      run0 = 0;
    end else begin
      if ((s0 && !ps0) || (r0 && !pr0))
        chk("u0_gap", int'(ps0 | pr0), 0);
      if (s0 && !ps0) ev(0, "S");
      if (r0 && !pr0) ev(0, "R");
      if (cf0) ev(0, "C");
      if (ov0) ev(0, "O");
      if (s0 || r0) begin
        run0++;
      end else if (ps0 || pr0) begin
        chk("u0_width", run0, PW0);
        run0 = 0;
      end
      ps0 = s0;
      pr0 = r0;
    end
  end

  // Monitor for unit 1.
  always @(negedge clk) begin
    chk("u1_excl", int'(s1 & r1), 0);
    if (!rst_n) begin
      ps1  = 1'b0;
      pr1  = 1'b0;
      run1 = 0;
    end else begin
      if ((s1 && !ps1) || (r1 && !pr1))
        chk("u1_gap", int'(ps1 | pr1), 0);
      if (s1 && !ps1) ev(1, "S");
      if (r1 && !pr1) ev(1, "R");
      if (cf1) ev(1, "C");
      if (ov1) ev(1, "O");
      if (s1 || r1) begin
        run1++;
      end else if (ps1 || pr1) begin
        chk("u1_width", run1, PW1);
        run1 = 0;
      end
      ps1 = s1;
      pr1 = r1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    rst_n = 1'b0;
    set0  = 1'b0;
    rst0  = 1'b0;
    set1  = 1'b0;
    rst1  = 1'b0;

    // Reset state
    at_neg(3);
    chk("rst_S", int'(s0), 0);
    chk("rst_R", int'(r0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_conflict", int'(cf0), 0);
    chk("rst_overrun", int'(ov0), 0);
    chk("rst_busy1", int'(busy1), 0);
    step(1);
    rst_n = 1'b1;
    step(3);

    // Clean set press
    n = cyc;
    set0 = 1'b1;
    push(0, "S", n + LAT);
    at_neg(n + 7);
    chk("p1_busy7", int'(busy0), 1);
    at_neg(n + 9);
    chk("p1_S9", int'(s0), 0);
    chk("p1_busy9", int'(busy0), 1);
    at_neg(n + 10);
    chk("p1_busy10", int'(busy0), 0);
    chk("p1_R", int'(r0), 0);
    step(10);
    set0 = 1'b0;
    step(14);
    chk("p1_drained", q0.size(), 0);

    // Bouncing set button
    for (int i = 0; i < 10; i++) begin
      set0 = ~set0;
      step(2);
    end
    set0 = 1'b0;
    step(16);
    chk("bounce_drained", q0.size(), 0);

    // Simultaneous presses
    n = cyc;
    set0 = 1'b1;
    rst0 = 1'b1;
    push(0, "C", n + 6);
    step(15);
    set0 = 1'b0;
    rst0 = 1'b0;
    step(14);
    chk("conf_drained", q0.size(), 0);

    // Reset queued behind a set pulse
    n = cyc;
    set0 = 1'b1;
    push(0, "S", n + LAT);
    push(0, "R", n + 11);
    step(1);
    rst0 = 1'b1;
    step(15);
    set0 = 1'b0;
    rst0 = 1'b0;
    step(14);
    chk("q_sr_drained", q0.size(), 0);

    // Set queued behind a reset pulse
    n = cyc;
    rst0 = 1'b1;
    push(0, "R", n + LAT);
    push(0, "S", n + 11);
    step(1);
    set0 = 1'b1;
    step(15);
    set0 = 1'b0;
    rst0 = 1'b0;
    step(14);
    chk("q_rs_drained", q0.size(), 0);

    // Overrun on unit 1: pending R replaced by S
    n = cyc;
    set1 = 1'b1;
    push(1, "S", n + LAT);
    push(1, "O", n + 15);
    push(1, "S", n + 25);
    step(1);
    rst1 = 1'b1;
    step(3);
    set1 = 1'b0;
    step(4);
    set1 = 1'b1;
    at_neg(n + 16);
    chk("ovr_busy", int'(busy1), 1);
    step(30);
    set1 = 1'b0;
    rst1 = 1'b0;
    step(14);
    chk("ovr_drained", q1.size(), 0);

    // Reset in the middle of a pulse
    n = cyc;
    set0 = 1'b1;
    push(0, "S", n + LAT);
    at_neg(n + 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_S", int'(s0), 0);
    chk("mid_R", int'(r0), 0);
    chk("mid_busy", int'(busy0), 0);
    chk("mid_conflict", int'(cf0), 0);
    chk("mid_overrun", int'(ov0), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    k = cyc;
    push(0, "S", k + LAT);
    step(14);
    set0 = 1'b0;
    step(14);
    chk("mid_drained", q0.size(), 0);
    chk("end_drained1", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
